// File: rtl/ufm_pkg.sv
// ufm_pkg: shared constants and types for the UFM burst reader.
//   UFM_AW      - UFM word address width
//   UFM_DW      - UFM data word width
//   ufm_state_e - reader FSM states
//   burst_len() - burst length chosen for a given remaining word count
package ufm_pkg;

   localparam int UFM_AW = 12;
   localparam int UFM_DW = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_FLIGHT = 2'd2,
      ST_FINISH = 2'd3
   } ufm_state_e;

   // Two-word bursts whenever possible, a single word for the odd tail.
   function automatic logic [1:0] burst_len(input logic [UFM_AW-1:0] remaining);
      return (remaining >= UFM_AW'(2)) ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clock, reset_n - clock and asynchronous active-low reset
//   push/push_data - write request and data (write accepted when not full,
//                    or when full together with a pop)
//   pop            - consume the head word (ignored when empty)
//   pop_data       - head word, valid whenever empty=0
//   empty          - no words stored
//   count          - number of stored words (0..DEPTH)
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign count    = count_reg;
   // Asynchronous read of the head gives fall-through behaviour: a word
   // written on one edge is visible right after it.
   assign pop_data = mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop) begin
         count_next = count_reg + CW'(1);
      end else if (!do_push && do_pop) begin
         count_next = count_reg - CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         count_reg <= count_next;
      end
   end

   // Storage carries no reset; emptiness is tracked by the counter alone.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

endmodule

// File: rtl/ufm_reader.sv
// ufm_reader: reads a block of 32-bit words from the UFM Avalon-MM data port
// using 1- or 2-word bursts and streams them out through a small FWFT FIFO.
//   clock, reset_n            - clock and asynchronous active-low reset
//   start, start_addr,
//   word_count                - transfer request (taken only while idle)
//   busy, done                - transfer in progress / one-cycle completion pulse
//   out_data, out_valid,
//   out_ready                 - output word stream (valid/ready handshake)
//   avmm_addr, avmm_read,
//   avmm_burstcount,
//   avmm_waitrequest          - Avalon-MM burst read command
//   avmm_readdata,
//   avmm_readdatavalid        - Avalon-MM read data return
module ufm_reader
   import ufm_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [UFM_AW-1:0] start_addr,
   input  logic [UFM_AW-1:0] word_count,
   output logic              busy,
   output logic              done,
   output logic [UFM_DW-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [UFM_AW-1:0] avmm_addr,
   output logic              avmm_read,
   output logic [1:0]        avmm_burstcount,
   input  logic              avmm_waitrequest,
   input  logic [UFM_DW-1:0] avmm_readdata,
   input  logic              avmm_readdatavalid
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   ufm_state_e        state_reg,      state_next;
   logic [UFM_AW-1:0] addr_reg,       addr_next;
   logic [UFM_AW-1:0] remaining_reg,  remaining_next;
   logic [1:0]        beats_left_reg, beats_left_next;
   logic              busy_reg,       busy_next;
   logic              done_reg,       done_next;

   logic [1:0]        burst;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     free_entries;
   logic              fifo_empty;
   logic              space_ok;
   logic              cmd_accept;
   logic              fifo_push;
   logic              fifo_pop;

   assign burst        = burst_len(remaining_reg);
   assign free_entries = CW'(FIFO_DEPTH) - fifo_count;
   assign space_ok     = (free_entries >= CW'(burst));

   // The command is driven straight from registered state. While waiting in
   // ISSUE nothing can be pushed, so free space only grows and the command
   // cannot drop or change during a waitrequest stall.
   assign avmm_read       = (state_reg == ST_ISSUE) && space_ok;
   assign avmm_addr       = addr_reg;
   assign avmm_burstcount = burst;
   assign cmd_accept      = avmm_read && !avmm_waitrequest;

   // Returned beats only count while a burst is outstanding; anything else
   // (e.g. stragglers from a burst abandoned by reset) is discarded.
   assign fifo_push = (state_reg == ST_FLIGHT) && avmm_readdatavalid;
   assign fifo_pop  = out_valid && out_ready;
   assign out_valid = !fifo_empty;

   assign busy = busy_reg;
   assign done = done_reg;

   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      remaining_next  = remaining_reg;
      beats_left_next = beats_left_reg;
      busy_next       = busy_reg;
      done_next       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               addr_next      = start_addr;
               remaining_next = word_count;
               busy_next      = 1'b1;
               state_next     = (word_count == '0) ? ST_FINISH : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_accept) begin
               // 12-bit add wraps 0xFFF+1 back to 0x000.
               addr_next       = addr_reg + {{(UFM_AW-2){1'b0}}, burst};
               remaining_next  = remaining_reg - {{(UFM_AW-2){1'b0}}, burst};
               beats_left_next = burst;
               state_next      = ST_FLIGHT;
            end
         end
         ST_FLIGHT: begin
            if (avmm_readdatavalid) begin
               beats_left_next = beats_left_reg - 2'd1;
               if (beats_left_reg == 2'd1) begin
                  state_next = (remaining_reg != '0) ? ST_ISSUE : ST_FINISH;
               end
            end
         end
         ST_FINISH: begin
            // Completion is signalled only once the consumer has drained
            // every word; busy drops in the same cycle done is high.
            if (fifo_empty) begin
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         addr_reg       <= '0;
         remaining_reg  <= '0;
         beats_left_reg <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         remaining_reg  <= remaining_next;
         beats_left_reg <= beats_left_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
      end
   end

   sync_fifo #(
      .WIDTH (UFM_DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (avmm_readdata),
      .pop       (fifo_pop),
      .pop_data  (out_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule
